// File: rtl/dic_ram_arbiter.sv
// rtl/dic_ram_arbiter.sv - LZW dictionary RAM owner: init sweep, then read/write arbitration
`timescale 1ns/1ps
module dic_ram_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int ROOT_CODES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StartInit,
  output logic              InitDone,
  output logic              Busy,
  input  logic              RdReq,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic              RdGnt,
  output logic [DATA_W-1:0] RdData,
  output logic              RdValid,
  input  logic              WrReq,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  output logic              WrGnt,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0] RamWrData,
  output logic              RamWe,
  output logic              RamRe,
  input  logic [DATA_W-1:0] RamRdData
);

  typedef enum logic [1:0] {UNINIT = 2'd0, INIT = 2'd1, SERVE = 2'd2} state_t;

  localparam logic [ADDR_W:0] INIT_END = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ROOT_LIM = (ADDR_W+1)'(ROOT_CODES);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
  logic              prio_wr_q, prio_wr_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic              init_done_q, init_done_d;
  logic              busy_q, busy_d;

  logic              rd_elig, wr_elig;
  logic              sweep_wr;
  logic [ADDR_W:0]   sweep_idx;

  // A requester granted last cycle is still holding Req this cycle, so it is masked once.
  assign rd_elig = RdReq && !rd_gnt_q;
  assign wr_elig = WrReq && !wr_gnt_q;

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    prio_wr_d     = prio_wr_q;
    rd_gnt_d      = 1'b0;
    wr_gnt_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_re_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    init_done_d   = init_done_q;
    busy_d        = busy_q;
    sweep_wr      = 1'b0;
    sweep_idx     = init_cnt_q;
    rd_pend_d     = rd_gnt_q;
    rd_valid_d    = rd_pend_q;
    rd_data_d     = rd_pend_q ? RamRdData : rd_data_q;

    case (state_q)
      UNINIT: begin
        if (StartInit) begin
          state_d   = INIT;
          busy_d    = 1'b1;
          sweep_wr  = 1'b1;
          sweep_idx = '0;
        end
      end
      INIT: begin
        if (init_cnt_q == INIT_END) begin
          state_d     = SERVE;
          busy_d      = 1'b0;
          init_done_d = 1'b1;
        end else begin
          sweep_wr = 1'b1;
        end
      end
      SERVE: begin
        if (StartInit) begin
          state_d     = INIT;
          busy_d      = 1'b1;
          init_done_d = 1'b0;
          sweep_wr    = 1'b1;
          sweep_idx   = '0;
        end else if (rd_elig && (!wr_elig || !prio_wr_q)) begin
          rd_gnt_d   = 1'b1;
          ram_re_d   = 1'b1;
          ram_addr_d = RdAddr;
          prio_wr_d  = !prio_wr_q;
        end else if (wr_elig) begin
          wr_gnt_d      = 1'b1;
          ram_we_d      = 1'b1;
          ram_addr_d    = WrAddr;
          ram_wr_data_d = WrData;
          prio_wr_d     = !prio_wr_q;
        end
      end
      default: state_d = UNINIT;
    endcase

    // Root codes map to themselves, every other entry is cleared.
    if (sweep_wr) begin
      ram_we_d      = 1'b1;
      ram_addr_d    = sweep_idx[ADDR_W-1:0];
      ram_wr_data_d = (sweep_idx < ROOT_LIM) ? DATA_W'(sweep_idx) : '0;
      init_cnt_d    = sweep_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= UNINIT;
      init_cnt_q    <= '0;
      prio_wr_q     <= 1'b0;
      rd_gnt_q      <= 1'b0;
      wr_gnt_q      <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      ram_we_q      <= 1'b0;
      ram_re_q      <= 1'b0;
      init_done_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      prio_wr_q     <= prio_wr_d;
      rd_gnt_q      <= rd_gnt_d;
      wr_gnt_q      <= wr_gnt_d;
      rd_pend_q     <= rd_pend_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      ram_we_q      <= ram_we_d;
      ram_re_q      <= ram_re_d;
      init_done_q   <= init_done_d;
      busy_q        <= busy_d;
    end
  end

  assign InitDone  = init_done_q;
  assign Busy      = busy_q;
  assign RdGnt     = rd_gnt_q;
  assign RdData    = rd_data_q;
  assign RdValid   = rd_valid_q;
  assign WrGnt     = wr_gnt_q;
  assign RamAddr   = ram_addr_q;
  assign RamWrData = ram_wr_data_q;
  assign RamWe     = ram_we_q;
  assign RamRe     = ram_re_q;

endmodule

// File: tb/tb_dic_ram_arbiter.sv
// tb/tb_dic_ram_arbiter.sv - randomized bench for dic_ram_arbiter against a dictionary model
`timescale 1ns/1ps
module tb_dic_ram_arbiter;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 16;
  localparam int ROOT_CODES = 256;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              StartInit;
  logic              InitDone, Busy;
  logic              RdReq;
  logic [ADDR_W-1:0] RdAddr;
  logic              RdGnt;
  logic [DATA_W-1:0] RdData;
  logic              RdValid;
  logic              WrReq;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              WrGnt;
  logic [ADDR_W-1:0] RamAddr;
  logic [DATA_W-1:0] RamWrData;
  logic              RamWe, RamRe;
  logic [DATA_W-1:0] RamRdData;

  always #5 clk = ~clk;

  dic_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROOT_CODES(ROOT_CODES)) dut (
    .clk(clk), .reset(reset), .StartInit(StartInit), .InitDone(InitDone), .Busy(Busy),
    .RdReq(RdReq), .RdAddr(RdAddr), .RdGnt(RdGnt), .RdData(RdData), .RdValid(RdValid),
    .WrReq(WrReq), .WrAddr(WrAddr), .WrData(WrData), .WrGnt(WrGnt),
    .RamAddr(RamAddr), .RamWrData(RamWrData), .RamWe(RamWe), .RamRe(RamRe),
    .RamRdData(RamRdData)
  );

  // Single-port RAM with one cycle of read latency.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (RamRe) RamRdData <= ram_mem[RamAddr];
    if (RamWe) ram_mem[RamAddr] <= RamWrData;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DATA_W-1:0] model_mem [DEPTH];
  int rq_due [$];
  logic [DATA_W-1:0] rq_dat [$];
  bit prio_read, last_rg, last_wg, rnd_en, hold;
  bit prev_rd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({InitDone, Busy, RdGnt, RdData, RdValid, WrGnt, RamAddr, RamWrData, RamWe, RamRe});
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return 12'h0F8 + 12'($urandom_range(0, 15));
  endfunction

  task automatic check_rd_return();
    if (rq_due.size() > 0 && rq_due[0] == cyc) begin
      check_eq("rd_valid", RdValid, 1);
      check_eq("rd_data", RdData, rq_dat[0]);
      void'(rq_due.pop_front());
      void'(rq_dat.pop_front());
    end else begin
      check_eq("rd_valid_idle", RdValid, 0);
    end
  endtask

  // One SERVE cycle: predict the grant from the request rules, then compare.
  task automatic step();
    logic er, ew, nrg, nwg;
    er = RdReq && !last_rg;
    ew = WrReq && !last_wg;
    if (er && ew) begin
      nrg = prio_read;
      nwg = !prio_read;
    end else begin
      nrg = er;
      nwg = ew;
    end
    if (nrg || nwg) prio_read = !prio_read;
    @(posedge clk); #1; cyc++;
    check_eq("rd_gnt", RdGnt, nrg);
    check_eq("wr_gnt", WrGnt, nwg);
    check_eq("ram_re", RamRe, nrg);
    check_eq("ram_we", RamWe, nwg);
    if (nrg) begin
      check_eq("rd_cmd_addr", RamAddr, RdAddr);
      rq_due.push_back(cyc + 2);
      rq_dat.push_back(model_mem[RdAddr]);
    end
    if (nwg) begin
      check_eq("wr_cmd", {RamAddr, RamWrData}, {WrAddr, WrData});
      model_mem[WrAddr] = WrData;
    end
    check_rd_return();
    last_rg = nrg;
    last_wg = nwg;
    if (nrg && !hold) RdReq = 1'b0;
    else if (!RdReq && rnd_en && $urandom_range(0, 2) == 0) begin
      RdReq  = 1'b1;
      RdAddr = rand_addr();
    end
    if (nwg && !hold) WrReq = 1'b0;
    else if (!WrReq && rnd_en && $urandom_range(0, 2) == 0) begin
      WrReq  = 1'b1;
      WrAddr = rand_addr();
      WrData = 16'($urandom);
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((RdReq || WrReq || rq_due.size() > 0) && n < max) begin
      step();
      n++;
    end
    check_eq("drain_timeout", {RdReq, WrReq, rq_due.size() != 0}, 0);
  endtask

  task automatic uninit_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; cyc++;
      check_eq("uninit", all_outs(), 0);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0; #1;
    check_eq("reset_async", all_outs(), 0);
    @(posedge clk); #1; cyc++;
    check_eq("reset_held", all_outs(), 0);
    reset     = 1'b1;
    StartInit = 1'b0;
    RdReq     = 1'b0;
    WrReq     = 1'b0;
    prio_read = 1'b1;
    last_rg   = 1'b0;
    last_wg   = 1'b0;
    rq_due.delete();
    rq_dat.delete();
  endtask

  task automatic sweep(input int abort_at, input int poke_at);
    logic [DATA_W-1:0] d;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = (a < ROOT_CODES) ? 16'(a) : 16'h0;
    StartInit = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk); #1; cyc++;
      StartInit = 1'b0;
      d = (k < ROOT_CODES) ? 16'(k) : 16'h0;
      check_eq("sweep", {RamWe, RamRe, Busy, InitDone, RdGnt, WrGnt, RamAddr, RamWrData},
               {6'b101000, 12'(k), d});
      check_rd_return();
      if (k == abort_at) begin
        apply_reset();
        return;
      end
      if (k == poke_at) StartInit = 1'b1;
    end
    @(posedge clk); #1; cyc++;
    check_eq("sweep_done", {RamWe, RamRe, Busy, InitDone, RdGnt, WrGnt, RamAddr, RamWrData},
             {6'b000100, 12'hFFF, 16'h0});
    check_rd_return();
    last_rg = 1'b0;
    last_wg = 1'b0;
  endtask

  initial begin
    reset = 1'b0; StartInit = 1'b0;
    RdReq = 1'b0; RdAddr = '0; WrReq = 1'b0; WrAddr = '0; WrData = '0;
    prio_read = 1'b1; last_rg = 1'b0; last_wg = 1'b0; rnd_en = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outs", all_outs(), 0);
    reset = 1'b1;

    RdReq = 1'b1; RdAddr = 12'h041;
    uninit_idle(3);
    sweep(-1, -1);
    drain(20);
    check_eq("t2_rd_data", RdData, 16'h0041);

    WrReq = 1'b1; WrAddr = 12'h100; WrData = 16'hABCD;
    drain(20);
    RdReq = 1'b1; RdAddr = 12'h100;
    drain(20);
    check_eq("t3_rd_data", RdData, 16'hABCD);

    rnd_en = 1'b1;
    repeat (400) step();
    rnd_en = 1'b0;
    drain(50);

    sweep(12'h200, -1);
    uninit_idle(3);
    sweep(-1, -1);

    RdReq = 1'b1; RdAddr = 12'h0F8;
    WrReq = 1'b1; WrAddr = 12'h0F8; WrData = 16'h1234;
    hold = 1'b1;
    step();
    check_eq("t4_first_rd", RdGnt, 1);
    prev_rd = RdGnt;
    repeat (9) begin
      step();
      check_eq("t4_one_cmd", RamRe ^ RamWe, 1);
      check_eq("t4_alt", RdGnt, !prev_rd);
      prev_rd = RdGnt;
    end
    hold = 1'b0;
    drain(20);

    RdReq = 1'b1; RdAddr = 12'h0FF;
    for (int n = 0; n < 10 && !last_rg; n++) step();
    check_eq("t6_rd_gnt", last_rg, 1);
    WrReq = 1'b1; WrAddr = 12'h0FF; WrData = 16'h5A5A;
    sweep(-1, 100);
    check_eq("t6_rd_delivered", rq_due.size(), 0);
    drain(20);
    RdReq = 1'b1; RdAddr = 12'h0FF;
    drain(20);
    check_eq("t6_readback", RdData, 16'h5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

endmodule
